// File: rtl/psk_bit_framer.sv
// -----------------------------------------------------------------------------
// psk_bit_framer
//
// Serial bit source for the PSK modulator. Payload bytes come in over a
// valid/ready handshake into a one-byte hold buffer. Each frame is sent as:
//   1. an alternating 1,0,1,0,... preamble of PREAMBLE_LEN bits;
//   2. the 8-bit SYNC_WORD, MSB first;
//   3. PAYLOAD_LEN payload bytes, MSB first.
// Each bit is held on data_out for BIT_DIV clocks.
//
// Ports
//   sys_clk    in   single clock for all logic
//   sys_rst    in   asynchronous, active-high reset
//   in_data    in   [7:0] payload byte
//   in_valid   in   in_data is valid
//   in_ready   out  hold buffer is empty and can take a byte (registered)
//   data_out   out  current serial bit, to the modulator's data_in
//   bit_strobe out  high in the first clock of every bit period
//   busy       out  a frame is in progress (state is not IDLE)
//   frame_done out  one-clock pulse after the last payload bit period
//   underrun   out  sticky flag: payload byte missing at a byte boundary
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is a flop that equals !full for the next cycle.
// in_valid without in_ready is ignored. in_data only has to be stable at the
// accepting edge.
// -----------------------------------------------------------------------------
module psk_bit_framer #(
  parameter int unsigned BIT_DIV      = 100,
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter logic [7:0]  SYNC_WORD    = 8'hD3,
  parameter int unsigned PAYLOAD_LEN  = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       data_out,
  output logic       bit_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int TW     = $clog2(BIT_DIV);
  localparam int BC_MAX = (PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8;
  localparam int CW     = $clog2(BC_MAX);
  localparam int BW     = $clog2(PAYLOAD_LEN + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SYNC     = 2'd2,
    PAYLOAD  = 2'd3
  } state_t;

  // FSM state is kept under a plain name so checkers can bind to it.
  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [BW-1:0] byte_cnt, byte_cnt_n;
  // Bits still to send in the current sync/payload byte; bit 7 of that byte
  // already sits on data_out, so only the lower seven are kept here.
  logic [6:0]    shifter, shifter_n;
  logic          data_n, done_n, under_n;

  logic [7:0]    hold;
  logic          full, full_n;
  logic          accept, load, bit_end;

  assign accept     = in_valid & in_ready;
  assign bit_end    = (timer == TW'(BIT_DIV - 1));
  assign busy       = (state != IDLE);
  assign bit_strobe = busy && (timer == '0);

  // A new byte takes priority over a load, so accept+load leaves full set.
  assign full_n = accept ? 1'b1 : (load ? 1'b0 : full);

  always_comb begin
    state_n    = state;
    timer_n    = bit_end ? '0 : timer + 1'b1;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shifter_n  = shifter;
    data_n     = data_out;
    done_n     = 1'b0;
    under_n    = underrun;
    load       = 1'b0;

    case (state)
      IDLE: begin
        timer_n    = '0;
        bit_cnt_n  = '0;
        byte_cnt_n = '0;
        data_n     = 1'b0;
        if (full) begin
          state_n = PREAMBLE;
          data_n  = 1'b1;
        end
      end

      PREAMBLE: begin
        if (bit_end) begin
          if (bit_cnt == CW'(PREAMBLE_LEN - 1)) begin
            state_n   = SYNC;
            bit_cnt_n = '0;
            data_n    = SYNC_WORD[7];
            shifter_n = SYNC_WORD[6:0];
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            // Bit k+1 of the preamble is ~(k+1)[0], which equals k[0].
            data_n    = bit_cnt[0];
          end
        end
      end

      SYNC, PAYLOAD: begin
        if (bit_end) begin
          if (bit_cnt != CW'(7)) begin
            bit_cnt_n = bit_cnt + 1'b1;
            data_n    = shifter[6];
            shifter_n = {shifter[5:0], 1'b0};
          end else if (state == PAYLOAD && byte_cnt == BW'(PAYLOAD_LEN - 1)) begin
            state_n = IDLE;
            data_n  = 1'b0;
            done_n  = 1'b1;
          end else if (full) begin
            load       = 1'b1;
            state_n    = PAYLOAD;
            bit_cnt_n  = '0;
            byte_cnt_n = (state == SYNC) ? '0 : byte_cnt + 1'b1;
            data_n     = hold[7];
            shifter_n  = hold[6:0];
          end else begin
            // Byte needed but none buffered: abandon the frame.
            state_n = IDLE;
            data_n  = 1'b0;
            under_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shifter    <= '0;
      data_out   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      hold       <= '0;
      full       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      shifter    <= shifter_n;
      data_out   <= data_n;
      frame_done <= done_n;
      underrun   <= under_n;
      full       <= full_n;
      in_ready   <= ~full_n;
      if (accept) hold <= in_data;
    end
  end

endmodule
